// File: rtl/fir_filter_if.sv
// Streaming sample interface for fir_filter: valid-qualified input samples and filtered results.
// Master is the sample source / result sink; slave is the filter.
interface fir_filter_if #(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 26
);
  logic                           valid_in;
  logic signed [INPUT_WIDTH-1:0]  din;
  logic                           valid_out;
  logic signed [OUTPUT_WIDTH-1:0] dout;

  modport master (output valid_in, output din, input valid_out, input dout);
  modport slave  (input valid_in, input din, output valid_out, output dout);
endinterface

// File: rtl/fir_filter.sv
// Pipelined direct-form FIR with optional symmetric/anti-symmetric pre-adder and binary adder tree.
// Latency 1+L cycles (L = enabled pipeline stages); one sample per clock, no backpressure or stall.
// Define FIR_FILTER_ROUND_EN to round half-up (instead of truncate) when dout is narrower than the full result.
module fir_filter #(
  parameter int INPUT_WIDTH        = 16,
  parameter int COEFF_WIDTH        = 8,
  parameter int OUTPUT_WIDTH       = 26,
  parameter int OUTPUT_WIDTH_FULL  = 26,
  parameter int SYMMETRY           = 0,
  parameter int NUM_TAPS           = 37,
  parameter logic signed [COEFF_WIDTH-1:0] COEFFS [NUM_TAPS] = '{default: '0},
  parameter int PIPELINE_MUL       = 1,
  parameter int PIPELINE_PREADD    = 1,
  parameter int PIPELINE_ADD_RATIO = 1,
  parameter int OUTPUT_REG         = 1
) (
  input logic         clk,
  input logic         rst,
  fir_filter_if.slave bus
);
  localparam int IW         = INPUT_WIDTH;
  localparam int FW         = OUTPUT_WIDTH_FULL;
  localparam int OW         = OUTPUT_WIDTH;
  localparam int HALF       = NUM_TAPS / 2;
  localparam int P          = (SYMMETRY == 0) ? NUM_TAPS : (NUM_TAPS + 1) / 2;
  localparam int D          = (P > 1) ? $clog2(P) : 0;
  localparam int RATIO_SAFE = (PIPELINE_ADD_RATIO > 0) ? PIPELINE_ADD_RATIO : 1;
  localparam int NREG_ADD   = (PIPELINE_ADD_RATIO > 0) ? D / RATIO_SAFE : 0;
  localparam int PRE_EN     = (SYMMETRY != 0 && PIPELINE_PREADD != 0) ? 1 : 0;
  localparam int LAT        = PRE_EN + ((PIPELINE_MUL != 0) ? 1 : 0) + NREG_ADD + ((OUTPUT_REG != 0) ? 1 : 0);
  localparam int VD         = LAT + 1;

  // Number of partial sums alive after adder-tree level k.
  function automatic int lvl_cnt(input int k);
    int n;
    n = P;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  logic signed [IW-1:0] taps [NUM_TAPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) taps[i] <= '0;
    end else if (bus.valid_in) begin
      taps[0] <= bus.din;
      for (int i = 1; i < NUM_TAPS; i++) taps[i] <= taps[i-1];
    end
  end

  logic signed [IW:0] pre_c [P];
  logic signed [IW:0] pre_q [P];

  // Mirrored taps fold together; the odd middle tap (and every tap when non-symmetric) passes alone.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      if (SYMMETRY == 0 || i >= HALF)
        pre_c[i] = {taps[i][IW-1], taps[i]};
      else if (SYMMETRY == 1)
        pre_c[i] = {taps[i][IW-1], taps[i]} + {taps[NUM_TAPS-1-i][IW-1], taps[NUM_TAPS-1-i]};
      else
        pre_c[i] = {taps[i][IW-1], taps[i]} - {taps[NUM_TAPS-1-i][IW-1], taps[NUM_TAPS-1-i]};
    end
  end

  if (PRE_EN != 0) begin : g_pre_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < P; i++) pre_q[i] <= '0;
      end else begin
        for (int i = 0; i < P; i++) pre_q[i] <= pre_c[i];
      end
    end
  end else begin : g_pre_comb
    assign pre_q = pre_c;
  end

  logic signed [FW-1:0] prod_c [P];

  always_comb begin
    for (int i = 0; i < P; i++) prod_c[i] = FW'(pre_q[i]) * FW'(COEFFS[i]);
  end

  // Level 0 holds the products; level k reduces pairs of level k-1, odd leftovers pass through.
  for (genvar k = 0; k <= D; k++) begin : lvl_g
    localparam int CNT    = lvl_cnt(k);
    localparam bit IS_REG = (k == 0) ? (PIPELINE_MUL != 0)
                                     : (PIPELINE_ADD_RATIO > 0 && (k % RATIO_SAFE) == 0);
    logic signed [FW-1:0] s_c [CNT];
    logic signed [FW-1:0] s   [CNT];

    if (k == 0) begin : g_src
      assign s_c = prod_c;
    end else begin : g_add
      localparam int PCNT = lvl_cnt(k - 1);
      for (genvar j = 0; j < CNT; j++) begin : node_g
        if (2 * j + 1 < PCNT) begin : g_sum
          assign s_c[j] = lvl_g[k-1].s[2*j] + lvl_g[k-1].s[2*j+1];
        end else begin : g_pass
          assign s_c[j] = lvl_g[k-1].s[2*j];
        end
      end
    end

    if (IS_REG) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < CNT; j++) s[j] <= '0;
        end else begin
          for (int j = 0; j < CNT; j++) s[j] <= s_c[j];
        end
      end
    end else begin : g_comb
      assign s = s_c;
    end
  end

  logic signed [FW-1:0] final_sum;
  logic signed [OW-1:0] scaled;

  assign final_sum = lvl_g[D].s[0];

  if (OW < FW) begin : g_narrow
    logic [FW-OW-1:0] unused_lsbs;
`ifdef FIR_FILTER_ROUND_EN
    localparam logic [FW-1:0] HALF_LSB = FW'(1) << (FW - OW - 1);
    logic signed [FW-1:0] rounded;
    assign rounded     = final_sum + HALF_LSB;
    assign scaled      = rounded[FW-1 -: OW];
    assign unused_lsbs = rounded[FW-OW-1:0];
`else
    assign scaled      = final_sum[FW-1 -: OW];
    assign unused_lsbs = final_sum[FW-OW-1:0];
`endif
  end else begin : g_wide
    assign scaled = OW'(final_sum);
  end

  logic signed [OW-1:0] dout_q;

  if (OUTPUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clk) begin
      if (rst) dout_q <= '0;
      else     dout_q <= scaled;
    end
  end else begin : g_out_comb
    assign dout_q = scaled;
  end

  // The extra stage over LAT accounts for the tap-line capture itself.
  logic [VD-1:0] vsr;

  always_ff @(posedge clk) begin
    if (rst) vsr <= '0;
    else     vsr <= VD'({vsr, bus.valid_in});
  end

  assign bus.dout      = dout_q;
  assign bus.valid_out = vsr[VD-1];
endmodule

// File: tb/tb_fir_filter.sv
// Drives several fir_filter configurations with one stimulus stream and checks each against a tap-sum reference model.
module tb_fir_filter;
  localparam int N    = 37;
  localparam int LMAX = 8;
  localparam int MAXE = 4096;

  typedef logic signed [7:0] coef_arr_t [N];

  localparam coef_arr_t C_SYM = '{
    8'sd8, 8'sd0, -8'sd4, 8'sd0, -8'sd6, 8'sd0, -8'sd8, 8'sd0, -8'sd10, 8'sd0, 8'sd12, 8'sd0,
    8'sd20, 8'sd0, 8'sd36, 8'sd0, 8'sd56, 8'sd90, 8'sd127, 8'sd90, 8'sd56, 8'sd0, 8'sd36, 8'sd0,
    8'sd20, 8'sd0, 8'sd12, 8'sd0, -8'sd10, 8'sd0, -8'sd8, 8'sd0, -8'sd6, 8'sd0, -8'sd4, 8'sd0, 8'sd8};

  localparam coef_arr_t C_ANTI = '{
    8'sd3, -8'sd7, 8'sd0, 8'sd12, -8'sd20, 8'sd0, 8'sd9, 8'sd4, -8'sd15, 8'sd30, 8'sd0, -8'sd2,
    8'sd18, -8'sd25, 8'sd40, -8'sd60, 8'sd11, 8'sd70, 8'sd5, -8'sd70, -8'sd11, 8'sd60, -8'sd40, 8'sd25,
    -8'sd18, 8'sd2, 8'sd0, -8'sd30, 8'sd15, -8'sd4, -8'sd9, 8'sd0, 8'sd20, -8'sd12, 8'sd0, 8'sd7, -8'sd3};

  logic               clk = 1'b0;
  logic               rst;
  logic               vin;
  logic signed [15:0] din;
  int                 checks = 0;
  int                 errors = 0;

  always #5 clk = ~clk;

  fir_filter_if #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(26)) if_dflt ();
  fir_filter_if #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(26)) if_sym1 ();
  fir_filter_if #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(26)) if_anti0 ();
  fir_filter_if #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(26)) if_anti2 ();
  fir_filter_if #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(26)) if_comb ();
  fir_filter_if #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(26)) if_r2 ();
  fir_filter_if #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(16)) if_narrow ();

  assign if_dflt.valid_in   = vin;  assign if_dflt.din   = din;
  assign if_sym1.valid_in   = vin;  assign if_sym1.din   = din;
  assign if_anti0.valid_in  = vin;  assign if_anti0.din  = din;
  assign if_anti2.valid_in  = vin;  assign if_anti2.din  = din;
  assign if_comb.valid_in   = vin;  assign if_comb.din   = din;
  assign if_r2.valid_in     = vin;  assign if_r2.din     = din;
  assign if_narrow.valid_in = vin;  assign if_narrow.din = din;

  fir_filter #(.COEFFS(C_SYM)) u_dflt (.clk(clk), .rst(rst), .bus(if_dflt));
  fir_filter #(.SYMMETRY(1), .COEFFS(C_SYM)) u_sym1 (.clk(clk), .rst(rst), .bus(if_sym1));
  fir_filter #(.COEFFS(C_ANTI)) u_anti0 (.clk(clk), .rst(rst), .bus(if_anti0));
  fir_filter #(.SYMMETRY(2), .COEFFS(C_ANTI)) u_anti2 (.clk(clk), .rst(rst), .bus(if_anti2));
  fir_filter #(.COEFFS(C_SYM), .PIPELINE_MUL(0), .PIPELINE_PREADD(0), .PIPELINE_ADD_RATIO(0),
               .OUTPUT_REG(0)) u_comb (.clk(clk), .rst(rst), .bus(if_comb));
  fir_filter #(.COEFFS(C_SYM), .PIPELINE_ADD_RATIO(2)) u_r2 (.clk(clk), .rst(rst), .bus(if_r2));
  fir_filter #(.COEFFS(C_SYM), .OUTPUT_WIDTH(16)) u_narrow (.clk(clk), .rst(rst), .bus(if_narrow));

  // Reference: per clock edge, the valid bit entering the filter and the dot product of the tap line.
  int     mt [N];
  logic   exp_v [MAXE];
  longint exp_s [MAXE];
  longint exp_a [MAXE];
  int     ecount = 0;
  longint msum_s, msum_a;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mt[i] = 0;
    end else if (vin) begin
      for (int i = N - 1; i > 0; i--) mt[i] = mt[i-1];
      mt[0] = int'(din);
    end
    msum_s = 0;
    msum_a = 0;
    for (int i = 0; i < N; i++) begin
      msum_s += longint'(mt[i]) * longint'(C_SYM[i]);
      msum_a += longint'(mt[i]) * longint'(C_ANTI[i]);
    end
    if (ecount < MAXE) begin
      exp_v[ecount] = vin && !rst;
      exp_s[ecount] = msum_s;
      exp_a[ecount] = msum_a;
      // Reset empties every in-flight stage, so results still queued behind it never appear.
      if (rst) begin
        for (int j = ecount - LMAX; j < ecount; j++) begin
          if (j >= 0) begin
            exp_v[j] = 1'b0;
            exp_s[j] = 0;
            exp_a[j] = 0;
          end
        end
      end
    end
    ecount++;
  end

  function automatic longint narrow(input longint full);
    longint             t;
    logic signed [15:0] n;
`ifdef FIR_FILTER_ROUND_EN
    t = (full + 512) >>> 10;
`else
    t = full >>> 10;
`endif
    n = 16'(t);
    return longint'(n);
  endfunction

  task automatic check_inst(input string tag, input logic v, input longint d, input int lat, input int sel);
    int     idx;
    logic   ev;
    longint ed;
    idx = ecount - 1 - lat;
    ev  = 1'b0;
    ed  = 0;
    if (idx >= 0 && idx < MAXE) begin
      ev = exp_v[idx];
      case (sel)
        0:       ed = exp_s[idx];
        1:       ed = exp_a[idx];
        default: ed = narrow(exp_s[idx]);
      endcase
    end
    checks++;
    assert (v === ev) else begin
      errors++;
      $error("FAIL %s valid_out got %0b want %0b (edge %0d)", tag, v, ev, ecount);
    end
    checks++;
    assert (d === ed) else begin
      errors++;
      $error("FAIL %s dout got %0d want %0d (edge %0d)", tag, d, ed, ecount);
    end
  endtask

  task automatic check_all();
    check_inst("dflt",   if_dflt.valid_out,   longint'(if_dflt.dout),   8, 0);
    check_inst("sym1",   if_sym1.valid_out,   longint'(if_sym1.dout),   8, 0);
    check_inst("anti0",  if_anti0.valid_out,  longint'(if_anti0.dout),  8, 1);
    check_inst("anti2",  if_anti2.valid_out,  longint'(if_anti2.dout),  8, 1);
    check_inst("comb",   if_comb.valid_out,   longint'(if_comb.dout),   0, 0);
    check_inst("ratio2", if_r2.valid_out,     longint'(if_r2.dout),     5, 0);
    check_inst("narrow", if_narrow.valid_out, longint'(if_narrow.dout), 8, 2);
  endtask

  task automatic chk_val(input string tag, input longint obs, input longint want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, obs, want);
    end
  endtask

  task automatic chk_raw(input string tag, input logic [25:0] obs, input logic [25:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s got 0x%07h want 0x%07h", tag, obs, want);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic signed [15:0] d);
    rst = r;
    vin = v;
    din = d;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [25:0]        raw;
    logic signed [15:0] rd;
    rst = 1'b1;
    vin = 1'b0;
    din = '0;

    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 16'sd0);
    for (int i = 0; i < 200; i++) begin
      cyc(1'b0, 1'b0, 16'sd0);
      if (i % 50 == 0) begin
        raw = if_dflt.dout;
        chk_raw("idle_dout", raw, 26'h0000000);
        chk_val("idle_valid", longint'(if_dflt.valid_out), 0);
      end
    end

    // Impulse: each output replays one coefficient scaled by -32768.
    cyc(1'b0, 1'b1, 16'sh8000);
    for (int j = 2; j <= 45; j++) begin
      cyc(1'b0, (j <= 37), 16'sd0);
      if (j >= 9) chk_val("impulse_k", longint'(if_dflt.dout), -32768 * longint'(C_SYM[j-9]));
      raw = if_dflt.dout;
      if (j == 9)  chk_raw("impulse_first", raw, 26'h3FC0000);
      if (j == 27) chk_raw("impulse_peak", raw, 26'h3C08000);
    end

    // Step: full-scale negative input settles at the coefficient sum.
    for (int j = 1; j <= 37; j++) cyc(1'b0, 1'b1, 16'sh8000);
    for (int j = 38; j <= 50; j++) begin
      cyc(1'b0, 1'b0, 16'sd0);
      if (j == 45) begin
        raw = if_dflt.dout;
        chk_raw("step_settle", raw, 26'h2FE8000);
        chk_val("step_valid_last", longint'(if_dflt.valid_out), 1);
      end
      if (j == 46) chk_val("step_valid_fall", longint'(if_dflt.valid_out), 0);
    end

    // Reset in the middle of a step discards everything in flight.
    for (int j = 1; j <= 20; j++) cyc(1'b0, 1'b1, 16'sh8000);
    cyc(1'b1, 1'b1, 16'sh8000);
    chk_val("midrst_valid", longint'(if_dflt.valid_out), 0);
    chk_val("midrst_dout", longint'(if_dflt.dout), 0);
    chk_val("midrst_comb_dout", longint'(if_comb.dout), 0);
    for (int j = 0; j < 15; j++) begin
      cyc(1'b0, 1'b0, 16'sd0);
      chk_val("midrst_stale_valid", longint'(if_dflt.valid_out), 0);
      chk_val("midrst_stale_dout", longint'(if_dflt.dout), 0);
    end

    // Random stream with gaps, occasional extremes and one short reset.
    for (int j = 0; j < 700; j++) begin
      case ($urandom_range(0, 9))
        0:       rd = 16'sh8000;
        1:       rd = 16'sh7FFF;
        default: rd = 16'($urandom);
      endcase
      cyc((j >= 400 && j < 402), ($urandom_range(0, 9) < 7), rd);
    end
    for (int j = 0; j < 12; j++) cyc(1'b0, 1'b0, 16'sd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
